// File: rtl/tachyon_imem_pkg.sv
// tachyon_imem_pkg: shared types and constants for the instruction-memory responder
package tachyon_imem_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h00000013;
  typedef enum logic [1:0] {EMPTY, LOAD, RUN} imem_state_e;
  function automatic logic even_parity(input logic [WORD_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/imem_responder_if.sv
// imem_responder_if: fetch, load and control signals between core/loader (master) and responder (slave)
interface imem_responder_if #(parameter int ADDR_WIDTH = 32);
  logic                  fetch_en;
  logic [ADDR_WIDTH-3:0] fetch_addr;
  logic [31:0]           fetch_insn;
  logic                  fetch_insn_valid;
  logic                  fetch_fault;
  logic                  load_valid;
  logic                  load_ready;
  logic [ADDR_WIDTH-3:0] load_addr;
  logic [31:0]           load_data;
  logic                  load_last;
  logic                  reload_req;
  logic                  mem_ready;
  logic                  load_err;
  modport master (
    output fetch_en, fetch_addr, load_valid, load_addr, load_data, load_last, reload_req,
    input  fetch_insn, fetch_insn_valid, fetch_fault, load_ready, mem_ready, load_err
  );
  modport slave (
    input  fetch_en, fetch_addr, load_valid, load_addr, load_data, load_last, reload_req,
    output fetch_insn, fetch_insn_valid, fetch_fault, load_ready, mem_ready, load_err
  );
endinterface

// File: rtl/imem_ram.sv
// imem_ram: single write port, single registered read port program RAM
module imem_ram #(
  parameter int DW         = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DW-1:0]         wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DW-1:0]         rdata
);
  logic [DW-1:0] mem [2**DEPTH_LOG2];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fetch-port memory with loadable program RAM and one-cycle fetch latency.
// Define TACHYON_IMEM_PARITY_EN to store and check an even-parity bit per word.
module imem_responder
  import tachyon_imem_pkg::*;
#(
  parameter int                ADDR_WIDTH = 32,
  parameter int                DEPTH_LOG2 = 10,
  parameter logic [WORD_W-1:0] NOP_INSN   = NOP_WORD
) (
  input logic              clk,
  input logic              rst,
  imem_responder_if.slave  bus
);
  localparam int WA = ADDR_WIDTH - 2;
`ifdef TACHYON_IMEM_PARITY_EN
  localparam int DW = WORD_W + 1;
`else
  localparam int DW = WORD_W;
`endif
  imem_state_e state, state_nxt;
  logic accept, we, re, load_oor, fetch_oor;
  logic rsp_en, rsp_run, rsp_oor, par_bad;
  logic [DW-1:0] wdata, rdata;
  logic [WORD_W-1:0] insn_hold;
  assign load_oor  = |bus.load_addr[WA-1:DEPTH_LOG2];
  assign fetch_oor = |bus.fetch_addr[WA-1:DEPTH_LOG2];
  always_ff @(posedge clk) state <= rst ? EMPTY : state_nxt;
  always_comb state_nxt = (state == RUN) ? (bus.reload_req ? EMPTY : RUN)
                        : accept ? (bus.load_last ? RUN : LOAD) : state;
  always_comb begin
    bus.load_ready = state != RUN;
    accept = bus.load_valid && state != RUN;
    we = accept && !load_oor && !rst;
    re = bus.fetch_en && state == RUN && !fetch_oor;
  end
`ifdef TACHYON_IMEM_PARITY_EN
  assign wdata   = {even_parity(bus.load_data), bus.load_data};
  assign par_bad = rsp_run && !rsp_oor && (^rdata);
`else
  assign wdata   = bus.load_data;
  assign par_bad = 1'b0;
`endif
  imem_ram #(.DW(DW), .DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(bus.load_addr[DEPTH_LOG2-1:0]),
    .wdata(wdata),
    .re   (re),
    .raddr(bus.fetch_addr[DEPTH_LOG2-1:0]),
    .rdata(rdata)
  );
  always_ff @(posedge clk) begin
    bus.mem_ready <= !rst && state_nxt == RUN;
    bus.load_err  <= !rst && (bus.load_err || (accept && load_oor));
    rsp_en        <= !rst && bus.fetch_en;
    rsp_run       <= state == RUN;
    rsp_oor       <= fetch_oor;
    insn_hold     <= rst ? NOP_INSN : bus.fetch_insn;
  end
  // With no request last cycle the output word simply holds.
  assign bus.fetch_insn = !rsp_en ? insn_hold
                        : (rsp_run && !rsp_oor && !par_bad) ? rdata[WORD_W-1:0] : NOP_INSN;
  assign bus.fetch_insn_valid = rsp_en && rsp_run;
  assign bus.fetch_fault      = rsp_en && rsp_run && (rsp_oor || par_bad);
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder: the memory side of the core's fetch port.
- Accepts a word-aligned fetch request (enable plus word address) and returns the instruction word one cycle later, with valid and fault qualifiers.
- Holds a loadable program RAM. A loader fills it over a valid/ready write channel before fetch is served.
- Sits between the core's fetch stage and the program loader/debug path.

Parameters:
- ADDR_WIDTH, 32, byte-address width; word addresses are [ADDR_WIDTH-1:2].
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words).
- NOP_INSN, 32'h00000013, word returned when no valid instruction is available.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fetch_en  in  1  fetch request this cycle.
- fetch_addr  in  ADDR_WIDTH-2  word address, [ADDR_WIDTH-1:2].
- fetch_insn  out  32  instruction word.
- fetch_insn_valid  out  1  fetch_insn carries a served request.
- fetch_fault  out  1  served request was out of range or corrupted.
- load_valid  in  1  load beat offered.
- load_ready  out  1  load beat can be accepted.
- load_addr  in  ADDR_WIDTH-2  word address of the load beat.
- load_data  in  32  instruction word to write.
- load_last  in  1  final beat of the program image.
- reload_req  in  1  in RUN, return to EMPTY to accept a new image.
- mem_ready  out  1  image loaded; fetch is being served.
- load_err  out  1  sticky: a load beat was out of range.

Behaviour:
- Reset values: state EMPTY, fetch_insn=NOP_INSN, fetch_insn_valid=0, fetch_fault=0, load_ready=1, mem_ready=0, load_err=0. RAM contents are not cleared.
- Reset mid-load or mid-run: next cycle is EMPTY. Any in-flight fetch response is dropped (valid=0).
- States: EMPTY, LOAD, RUN.
- EMPTY -> LOAD on an accepted beat with load_last=0.
- EMPTY or LOAD -> RUN on an accepted beat with load_last=1.
- RUN -> EMPTY on reload_req; reload_req is ignored outside RUN.
- A beat is accepted when load_valid && load_ready.
- load_ready=1 in EMPTY and LOAD, 0 in RUN.
- Accepted beat writes RAM[load_addr[DEPTH_LOG2-1:0]] at the clock edge.
- Any nonzero load_addr bit above DEPTH_LOG2-1 on an accepted beat: write dropped, load_err set. load_err clears only on reset.
- mem_ready is registered: mem_ready=(state==RUN). It rises on the cycle after the last beat is accepted.
- Fetch latency is 1 cycle. fetch_en=1 at edge N in RUN produces at N+1: fetch_insn=RAM[addr], valid=1, fault=0.
- Out-of-range fetch (upper address bits nonzero): fetch_insn=NOP_INSN, valid=1, fault=1.
- fetch_en=1 in EMPTY or LOAD: valid=0, fault=0, fetch_insn=NOP_INSN.
- fetch_en=0: valid=0, fault=0, fetch_insn holds its previous value.
- Back-to-back fetches: one response per cycle, no bubbles.
- Fetch and reload_req in the same RUN cycle: the fetch is served. RUN -> EMPTY takes effect on the next cycle.
- Read-during-write cannot occur, because writes happen only outside RUN.
- Address wrap is not supported; the upper-bit check covers every out-of-range address.

Optional Feature:
- Macro TACHYON_IMEM_PARITY_EN.
- Defined:
  - RAM is 33 bits wide; bit 32 holds even parity of load_data, computed at write.
  - On an in-range fetch, a parity mismatch forces fetch_insn=NOP_INSN, fault=1, valid=1 in the response cycle.
- Undefined:
  - RAM is 32 bits wide; no check is made.
  - fault is asserted only for out-of-range fetches.
- Port list is identical in both builds.

Decomposition:
- Package tachyon_imem_pkg:
  - state enum imem_state_e {EMPTY, LOAD, RUN}.
  - NOP constant 32'h00000013.
  - word-width localparam 32.
- Sub-module imem_ram: single write port, single registered read port, data width 32 or 33, depth 2**DEPTH_LOG2.
- The responder owns the FSM, range checks, parity compute/check and output muxing.

Test Plan:
- Reset, then fetch_en=1 addr 0 -> next cycle valid=0, fetch_insn=0x00000013. load_ready=1, mem_ready=0.
- Load 4 beats {0:0x11111111, 1:0x22222222, 2:0x33333333, 3:0x44444444}, last on beat 3 -> mem_ready=1 the cycle after beat 3. Back-to-back fetches of addr 3,0,2 -> the next three cycles return 0x44444444, 0x11111111, 0x33333333, valid=1 each.
- In RUN, fetch word addr 1<<DEPTH_LOG2 -> next cycle valid=1, fault=1, fetch_insn=0x00000013.
- Load beat at word addr 0x400 with DEPTH_LOG2=10 -> load_err=1, RAM unchanged. load_err stays 1 through RUN until reset.
- In RUN, fetch_en with reload_req same cycle -> fetch served next cycle. load_ready=1, mem_ready=0 thereafter. Reset asserted mid-LOAD -> EMPTY, no response valid.
- With TACHYON_IMEM_PARITY_EN: back-door flip bit 5 of word 2, fetch addr 2 -> fault=1, fetch_insn=0x00000013. Without the macro the corrupted word is returned with fault=0.
